// File: rtl/core_pkg.sv
// Shared types for the decode/execute boundary: the packed control bundle,
// the decoded bundle layout, and small pointer helpers for the issue queue.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       jump_cond;
    logic [2:0] jump_cond_type;
    logic [3:0] alu_control;
    logic [2:0] srcs;
    logic [1:0] result_src;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef struct packed {
    ctrl_t             ctrl;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc4;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } de_bundle_t;

  // Pointers wrap at depth, which need not be a power of two.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  // True when slot idx lies within the cnt entries starting at head.
  function automatic logic slot_occupied(input int idx, input int head,
                                         input int cnt, input int depth);
    int rel;
    rel = (idx >= head) ? idx - head : idx + depth - head;
    return rel < cnt;
  endfunction

endpackage

// File: rtl/operand_snoop.sv
// Per-entry writeback snoop: replaces a source operand with the writeback
// result when the writeback targets that source register (never x0).
module operand_snoop #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [XLEN-1:0]   rd1_in,
  input  logic [XLEN-1:0]   rd2_in,
  output logic [XLEN-1:0]   rd1_out,
  output logic [XLEN-1:0]   rd2_out
);

  logic wb_live;
  logic hit1;
  logic hit2;

  assign wb_live = wb_reg_write && (wb_rd != '0);
  assign hit1    = wb_live && (wb_rd == rs1);
  assign hit2    = wb_live && (wb_rd == rs2);

  assign rd1_out = hit1 ? wb_result : rd1_in;
  assign rd2_out = hit2 ? wb_result : rd2_in;

endmodule

// File: rtl/decode_issue_queue.sv
// In-order decode->execute buffer with valid/ready handshake. Queued entries
// snoop the writeback bus so their operands stay current while they wait.
module decode_issue_queue
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_pc4,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_rd1,
  input  logic [XLEN-1:0]   in_rd2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_pc4,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_rd1,
  output logic [XLEN-1:0]   out_rd2,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [CNT_W-1:0]  count
);

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high. in_ready = (count<DEPTH) | out_ready; out_valid = (count!=0).

  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [XLEN-1:0]   pc_q   [DEPTH];
  logic [XLEN-1:0]   pc_d   [DEPTH];
  logic [XLEN-1:0]   pc4_q  [DEPTH];
  logic [XLEN-1:0]   pc4_d  [DEPTH];
  logic [XLEN-1:0]   imm_q  [DEPTH];
  logic [XLEN-1:0]   imm_d  [DEPTH];
  logic [XLEN-1:0]   rd1_q  [DEPTH];
  logic [XLEN-1:0]   rd1_d  [DEPTH];
  logic [XLEN-1:0]   rd2_q  [DEPTH];
  logic [XLEN-1:0]   rd2_d  [DEPTH];
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [REG_AW-1:0] rd_d   [DEPTH];
  logic [REG_AW-1:0] rs1_q  [DEPTH];
  logic [REG_AW-1:0] rs1_d  [DEPTH];
  logic [REG_AW-1:0] rs2_q  [DEPTH];
  logic [REG_AW-1:0] rs2_d  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Index DEPTH holds the snooped operands of the incoming bundle.
  logic [XLEN-1:0] snp_rd1 [DEPTH+1];
  logic [XLEN-1:0] snp_rd2 [DEPTH+1];

  for (genvar g = 0; g <= DEPTH; g++) begin : g_snoop
    if (g < DEPTH) begin : g_entry
      operand_snoop #(.XLEN(XLEN), .REG_AW(REG_AW)) u_snoop (
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .rs1          (rs1_q[g]),
        .rs2          (rs2_q[g]),
        .rd1_in       (rd1_q[g]),
        .rd2_in       (rd2_q[g]),
        .rd1_out      (snp_rd1[g]),
        .rd2_out      (snp_rd2[g])
      );
    end else begin : g_incoming
      operand_snoop #(.XLEN(XLEN), .REG_AW(REG_AW)) u_snoop (
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .rs1          (in_rs1),
        .rs2          (in_rs2),
        .rd1_in       (in_rd1),
        .rd2_in       (in_rd2),
        .rd1_out      (snp_rd1[g]),
        .rd2_out      (snp_rd2[g])
      );
    end
  end

  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q < CNT_W'(DEPTH)) | out_ready;
  assign count     = count_q;

  // Flush wins over both handshakes on the same edge.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = PTR_W'(ptr_inc(int'(tail_q), DEPTH));
      if (pop)  head_d = PTR_W'(ptr_inc(int'(head_q), DEPTH));
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ctrl_d[i] = ctrl_q[i];
      pc_d[i]   = pc_q[i];
      pc4_d[i]  = pc4_q[i];
      imm_d[i]  = imm_q[i];
      rd1_d[i]  = rd1_q[i];
      rd2_d[i]  = rd2_q[i];
      rd_d[i]   = rd_q[i];
      rs1_d[i]  = rs1_q[i];
      rs2_d[i]  = rs2_q[i];
      // The entry leaving this edge keeps its old operands; EX forwarding covers it.
      if (slot_occupied(i, int'(head_q), int'(count_q), DEPTH) &&
          !(pop && (head_q == PTR_W'(i)))) begin
        rd1_d[i] = snp_rd1[i];
        rd2_d[i] = snp_rd2[i];
      end
      if (push && (tail_q == PTR_W'(i))) begin
        ctrl_d[i] = in_ctrl;
        pc_d[i]   = in_pc;
        pc4_d[i]  = in_pc4;
        imm_d[i]  = in_imm;
        rd1_d[i]  = snp_rd1[DEPTH];
        rd2_d[i]  = snp_rd2[DEPTH];
        rd_d[i]   = in_rd;
        rs1_d[i]  = in_rs1;
        rs2_d[i]  = in_rs2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
        pc_q[i]   <= '0;
        pc4_q[i]  <= '0;
        imm_q[i]  <= '0;
        rd1_q[i]  <= '0;
        rd2_q[i]  <= '0;
        rd_q[i]   <= '0;
        rs1_q[i]  <= '0;
        rs2_q[i]  <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      imm_q   <= imm_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  // An empty queue presents a bubble: every field zero, so no side effects in EX.
  always_comb begin
    out_ctrl = '0;
    out_pc   = '0;
    out_pc4  = '0;
    out_imm  = '0;
    out_rd1  = '0;
    out_rd2  = '0;
    out_rd   = '0;
    out_rs1  = '0;
    out_rs2  = '0;
    if (out_valid) begin
      out_ctrl = ctrl_q[head_q];
      out_pc   = pc_q[head_q];
      out_pc4  = pc4_q[head_q];
      out_imm  = imm_q[head_q];
      out_rd1  = rd1_q[head_q];
      out_rd2  = rd2_q[head_q];
      out_rd   = rd_q[head_q];
      out_rs1  = rs1_q[head_q];
      out_rs2  = rs2_q[head_q];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(in_valid && !in_ready && push));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count_q == '0)));

endmodule
